// File: rtl/usr_irq_pkg.sv
// Shared encodings for the user IRQ arbiter.
// The READ state is only part of the state type when USR_IRQ_READBACK_EN is defined.
package usr_irq_pkg;

    localparam int          IRQ_ADDR_W = 4;
    localparam logic [31:0] IRQ_SET    = 32'h1;
    localparam logic [31:0] IRQ_CLR    = 32'h0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

`ifdef USR_IRQ_READBACK_EN
    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        WRITE = ST_WRITE,
        READ  = ST_READ
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        WRITE = ST_WRITE
    } state_t;
`endif

    function automatic logic [31:0] irq_wdata(input logic level);
        return level ? IRQ_SET : IRQ_CLR;
    endfunction

endpackage

// File: rtl/usr_irq_rr_pick.sv
// Combinational round-robin picker: first pending index at or above rr_ptr,
// wrapping modulo N_SRC.
module usr_irq_rr_pick
    import usr_irq_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_SRC-1:0] pending,
    input  logic [SEL_W-1:0] rr_ptr,
    output logic             valid,
    output logic [SEL_W-1:0] sel
);

    function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base,
                                                  input int unsigned      off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= unsigned'(N_SRC))
            s = s - unsigned'(N_SRC);
        return SEL_W'(s);
    endfunction

    // Scan from the farthest offset down so the nearest pending source wins.
    always_comb begin
        valid = 1'b0;
        sel   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pending[wrap_idx(rr_ptr, unsigned'(i))]) begin
                valid = 1'b1;
                sel   = wrap_idx(rr_ptr, unsigned'(i));
            end
        end
    end

endmodule

// File: rtl/usr_irq_arbiter.sv
// Serialises per-source IRQ level changes onto one Avalon-MM master, round-robin.
// Optional USR_IRQ_READBACK_EN adds a readback cycle and sticky mismatch flags.
module usr_irq_arbiter
    import usr_irq_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_SRC-1:0]      usr_irq_in,
    output logic                  irq_avalon_master_chipselect,
    output logic [IRQ_ADDR_W-1:0] irq_avalon_master_address,
    output logic                  irq_avalon_master_read,
    output logic                  irq_avalon_master_write,
    output logic [31:0]           irq_avalon_master_writedata,
    input  logic                  irq_avalon_master_waitrequest,
    input  logic [31:0]           irq_avalon_master_readdata,
    output logic                  busy,
    output logic [N_SRC-1:0]      irq_err
);

    localparam int ADDR_W = IRQ_ADDR_W;
    localparam int SEL_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    state_t           state;
    logic [N_SRC-1:0] usr_irq_r;
    logic [N_SRC-1:0] reported;
    logic [N_SRC-1:0] pending;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] sel_r;
    logic             val_r;
    logic             pick_valid;
    logic [SEL_W-1:0] pick_sel;

    // With N_SRC=1 the compare is always true, so rr_ptr stays 0.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] s);
        if (int'(s) >= N_SRC - 1)
            return '0;
        return s + SEL_W'(1);
    endfunction

    assign pending = usr_irq_r ^ reported;
    assign busy    = (state != IDLE);

    usr_irq_rr_pick #(
        .N_SRC (N_SRC),
        .SEL_W (SEL_W)
    ) u_pick (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .valid   (pick_valid),
        .sel     (pick_sel)
    );

`ifdef USR_IRQ_READBACK_EN
    logic unused_rdata;
    assign unused_rdata = ^irq_avalon_master_readdata[31:1];
`else
    logic unused_rdata;
    assign unused_rdata           = ^irq_avalon_master_readdata;
    assign irq_avalon_master_read = 1'b0;
    assign irq_err                = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                        <= IDLE;
            usr_irq_r                    <= '0;
            reported                     <= '0;
            rr_ptr                       <= '0;
            sel_r                        <= '0;
            val_r                        <= 1'b0;
            irq_avalon_master_chipselect <= 1'b0;
            irq_avalon_master_write      <= 1'b0;
            irq_avalon_master_address    <= '0;
            irq_avalon_master_writedata  <= '0;
`ifdef USR_IRQ_READBACK_EN
            irq_avalon_master_read       <= 1'b0;
            irq_err                      <= '0;
`endif
        end else begin
            usr_irq_r <= usr_irq_in;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        sel_r                        <= pick_sel;
                        val_r                        <= usr_irq_r[pick_sel];
                        irq_avalon_master_chipselect <= 1'b1;
                        irq_avalon_master_write      <= 1'b1;
                        irq_avalon_master_address    <= ADDR_W'(pick_sel);
                        irq_avalon_master_writedata  <= irq_wdata(usr_irq_r[pick_sel]);
                        state                        <= WRITE;
                    end else begin
                        irq_avalon_master_chipselect <= 1'b0;
                        irq_avalon_master_write      <= 1'b0;
                        irq_avalon_master_address    <= '0;
                        irq_avalon_master_writedata  <= '0;
                    end
                end
                WRITE: begin
                    if (!irq_avalon_master_waitrequest) begin
                        reported[sel_r]             <= val_r;
                        rr_ptr                      <= next_ptr(sel_r);
                        irq_avalon_master_write     <= 1'b0;
                        irq_avalon_master_writedata <= IRQ_CLR;
`ifdef USR_IRQ_READBACK_EN
                        // chipselect and address carry over into the read.
                        irq_avalon_master_read      <= 1'b1;
                        state                       <= READ;
`else
                        irq_avalon_master_chipselect <= 1'b0;
                        irq_avalon_master_address    <= '0;
                        state                        <= IDLE;
`endif
                    end
                end
`ifdef USR_IRQ_READBACK_EN
                READ: begin
                    if (!irq_avalon_master_waitrequest) begin
                        if (irq_avalon_master_readdata[0] != val_r)
                            irq_err[sel_r] <= 1'b1;
                        irq_avalon_master_chipselect <= 1'b0;
                        irq_avalon_master_read       <= 1'b0;
                        irq_avalon_master_address    <= '0;
                        state                        <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
